n64_vinfo_ctrl: RTL and testbench

N64_VINFO_CTRL -- requirements
Module: n64_vinfo_ctrl

---
 rtl/n64_vinfo_ctrl_pkg.sv | 40 ++++
 rtl/n64_sync_edge.sv | 19 +
 rtl/n64_vinfo_ctrl.sv | 136 +++++++++++++
 tb/tb_n64_vinfo_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_vinfo_ctrl_pkg.sv
// Shared constants for the N64 video-info controller: data bus width,
// sync bit positions, de-blur parameter packing and mode-detection limits.
package n64a_params;

  // Video data bus width and sync-word bit indices on D_i
  localparam int color_width_i = 7;
  localparam int VSYNC_BIT     = 3;
  localparam int HSYNC_BIT     = 1;
  localparam int CSYNC_BIT     = 0;

  // Bit order inside the registered sync word {nVSYNC, nHSYNC, nCSYNC}
  localparam int SYNC_V = 2;
  localparam int SYNC_H = 1;
  localparam int SYNC_C = 0;
  localparam logic [2:0] SYNC_RST = 3'b111;

  // deblurparams_o packing
  localparam int DBP_W        = 7;
  localparam int DBP_DCNT_HI  = 6;
  localparam int DBP_DCNT_LO  = 5;
  localparam int DBP_480I     = 4;
  localparam int DBP_VMODE    = 3;
  localparam int DBP_BLUR     = 2;
  localparam int DBP_NFORCE   = 1;
  localparam int DBP_NDEBLUR  = 0;

  // Line counting and mode detection
  localparam int LINE_CNT_W = 10;
  localparam logic [LINE_CNT_W-1:0] LINE_CNT_MAX    = '1;
  localparam logic [LINE_CNT_W-1:0] PAL_LINE_THRESH = 10'd288;

  // 480i hysteresis: number of consecutive disagreeing frames before a change
  localparam int HYST_DEPTH = 2;
  localparam int HYST_W     = $clog2(HYST_DEPTH);
  localparam logic [HYST_W-1:0] HYST_LAST = HYST_W'(HYST_DEPTH - 1);

  // Frame counter saturates here; its MSB is the valid flag
  localparam logic [1:0] FRAME_CNT_SAT = 2'b10;

endpackage

// File: rtl/n64_sync_edge.sv
// Falling-edge detector for nHSYNC / nVSYNC. Compares the sync word latched
// at the previous nDSYNC-low edge with the sync bits currently on the bus.
module n64_sync_edge (
  input  logic ndsync_i,
  input  logic prev_nvsync_i,
  input  logic prev_nhsync_i,
  input  logic nvsync_i,
  input  logic nhsync_i,
  output logic new_line_o,
  output logic new_frame_o
);

  // Strobes are only meaningful while the current word is a sync word
  always_comb begin
    new_line_o  = ~ndsync_i & prev_nhsync_i & ~nhsync_i;
    new_frame_o = ~ndsync_i & prev_nvsync_i & ~nvsync_i;
  end

endmodule

// File: rtl/n64_vinfo_ctrl.sv
// N64 video-info controller: tags R/G/B words, tracks blurry pixel position,
// counts lines per frame to detect PAL/NTSC and 480i, and latches the user
// de-blur settings once per frame. All state advances on the falling nCLK edge.
module n64_vinfo_ctrl
  import n64a_params::*;
(
  input  logic                     nCLK,
  input  logic                     RST,
  input  logic                     nDSYNC,
  input  logic [color_width_i-1:0] D_i,
  input  logic                     nForceDeBlur_i,
  input  logic                     nDeBlurMan_i,
  output logic [DBP_W-1:0]         deblurparams_o,
  output logic                     vinfo_valid_o
);

  logic [2:0]            sync_q, sync_d, sync_now;
  logic                  new_line, new_frame;
  logic [1:0]            data_cnt_q, data_cnt_d;
  logic                  n64_480i_q, n64_480i_d;
  logic                  vmode_q, vmode_d;
  logic                  blurry_q, blurry_d;
  logic                  nforce_q, nforce_d;
  logic                  ndeblur_q, ndeblur_d;
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [LINE_CNT_W-1:0] last_lines_q, last_lines_d;
  logic [HYST_W-1:0]     hyst_q, hyst_d;
  logic [1:0]            frame_cnt_q, frame_cnt_d;
  logic                  lsb_diff;
  logic                  unused_bits;

  assign sync_now = {D_i[VSYNC_BIT], D_i[HSYNC_BIT], D_i[CSYNC_BIT]};

  // Pixel data bits and nCSYNC are carried but not interpreted here
  assign unused_bits = ^{D_i[color_width_i-1:4], D_i[2], sync_q[SYNC_C]};

  n64_sync_edge u_sync_edge (
    .ndsync_i      (nDSYNC),
    .prev_nvsync_i (sync_q[SYNC_V]),
    .prev_nhsync_i (sync_q[SYNC_H]),
    .nvsync_i      (sync_now[SYNC_V]),
    .nhsync_i      (sync_now[SYNC_H]),
    .new_line_o    (new_line),
    .new_frame_o   (new_frame)
  );

  // Next-state logic; a frame event pre-empts a coincident line event
  always_comb begin
    sync_d       = sync_q;
    data_cnt_d   = data_cnt_q + 2'd1;
    n64_480i_d   = n64_480i_q;
    vmode_d      = vmode_q;
    blurry_d     = blurry_q;
    nforce_d     = nforce_q;
    ndeblur_d    = ndeblur_q;
    line_cnt_d   = line_cnt_q;
    last_lines_d = last_lines_q;
    hyst_d       = hyst_q;
    frame_cnt_d  = frame_cnt_q;
    // Odd/even line-count alternation between frames indicates interlace
    lsb_diff     = line_cnt_q[0] ^ last_lines_q[0];

    if (!nDSYNC) begin
      data_cnt_d = 2'b01;
      sync_d     = sync_now;
      blurry_d   = new_line ? 1'b0 : ~blurry_q;
    end

    if (new_frame) begin
      last_lines_d = line_cnt_q;
      line_cnt_d   = '0;
      vmode_d      = (line_cnt_q >= PAL_LINE_THRESH);
      nforce_d     = nForceDeBlur_i;
      ndeblur_d    = nDeBlurMan_i;
      if (frame_cnt_q != FRAME_CNT_SAT) begin
        frame_cnt_d = frame_cnt_q + 2'd1;
      end
      if (lsb_diff != n64_480i_q) begin
        if (hyst_q == HYST_LAST) begin
          n64_480i_d = lsb_diff;
          hyst_d     = '0;
        end else begin
          hyst_d = hyst_q + HYST_W'(1);
        end
      end else begin
        hyst_d = '0;
      end
    end else if (new_line) begin
      if (line_cnt_q != LINE_CNT_MAX) begin
        line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
      end
    end
  end

  // State registers; synchronous reset wins over every event
  always_ff @(negedge nCLK) begin
    if (RST) begin
      sync_q       <= SYNC_RST;
      data_cnt_q   <= 2'b00;
      n64_480i_q   <= 1'b0;
      vmode_q      <= 1'b0;
      blurry_q     <= 1'b0;
      nforce_q     <= 1'b1;
      ndeblur_q    <= 1'b1;
      line_cnt_q   <= '0;
      last_lines_q <= '0;
      hyst_q       <= '0;
      frame_cnt_q  <= 2'b00;
    end else begin
      sync_q       <= sync_d;
      data_cnt_q   <= data_cnt_d;
      n64_480i_q   <= n64_480i_d;
      vmode_q      <= vmode_d;
      blurry_q     <= blurry_d;
      nforce_q     <= nforce_d;
      ndeblur_q    <= ndeblur_d;
      line_cnt_q   <= line_cnt_d;
      last_lines_q <= last_lines_d;
      hyst_q       <= hyst_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Outputs are straight register taps
  always_comb begin
    deblurparams_o                          = '0;
    deblurparams_o[DBP_DCNT_HI:DBP_DCNT_LO] = data_cnt_q;
    deblurparams_o[DBP_480I]                = n64_480i_q;
    deblurparams_o[DBP_VMODE]               = vmode_q;
    deblurparams_o[DBP_BLUR]                = blurry_q;
    deblurparams_o[DBP_NFORCE]              = nforce_q;
    deblurparams_o[DBP_NDEBLUR]             = ndeblur_q;
    vinfo_valid_o                           = frame_cnt_q[1];
  end

endmodule

// File: tb/tb_n64_vinfo_ctrl.sv
// Bench for n64_vinfo_ctrl: directed scenarios plus random traffic, all
// checked against a behavioural model of the video-info rules.
module tb_n64_vinfo_ctrl;

  logic       nCLK           = 1'b1;
  logic       RST            = 1'b1;
  logic       nDSYNC         = 1'b1;
  logic [6:0] D_i            = 7'h7f;
  logic       nForceDeBlur_i = 1'b1;
  logic       nDeBlurMan_i   = 1'b1;
  logic [6:0] deblurparams_o;
  logic       vinfo_valid_o;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  // model state
  int m_dc, m_frames, m_lines, m_last, m_dis;
  bit m_480i, m_vmode, m_blur, m_nf, m_nd, m_pv, m_ph;

  n64_vinfo_ctrl dut (
    .nCLK           (nCLK),
    .RST            (RST),
    .nDSYNC         (nDSYNC),
    .D_i            (D_i),
    .nForceDeBlur_i (nForceDeBlur_i),
    .nDeBlurMan_i   (nDeBlurMan_i),
    .deblurparams_o (deblurparams_o),
    .vinfo_valid_o  (vinfo_valid_o)
  );

  // clock: falling edges at 5, 15, ...; inputs change on rising edges
  always #5 nCLK = ~nCLK;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model, one step per falling edge
  task automatic model_step();
    bit nl, nf, diff;
    if (RST) begin
      m_dc = 0; m_480i = 0; m_vmode = 0; m_blur = 0; m_nf = 1; m_nd = 1;
      m_frames = 0; m_lines = 0; m_last = 0; m_dis = 0; m_pv = 1; m_ph = 1;
    end else begin
      nl = 0;
      nf = 0;
      if (!nDSYNC) begin
        nl     = m_ph && !D_i[1];
        nf     = m_pv && !D_i[3];
        m_dc   = 1;
        m_blur = nl ? 1'b0 : !m_blur;
        m_pv   = D_i[3];
        m_ph   = D_i[1];
      end else begin
        m_dc = (m_dc + 1) % 4;
      end
      if (nf) begin
        diff = (m_lines % 2) != (m_last % 2);
        if (diff != m_480i) begin
          m_dis++;
          if (m_dis == 2) begin
            m_480i = diff;
            m_dis  = 0;
          end
        end else begin
          m_dis = 0;
        end
        m_vmode = (m_lines >= 288);
        m_last  = m_lines;
        m_lines = 0;
        if (m_frames < 2) m_frames++;
        m_nf = nForceDeBlur_i;
        m_nd = nDeBlurMan_i;
      end else if (nl) begin
        m_lines = (m_lines < 1023) ? m_lines + 1 : 1023;
      end
    end
  endtask

  function automatic logic [6:0] exp_dbp();
    logic [1:0] dc;
    dc = m_dc[1:0];
    return {dc, m_480i, m_vmode, m_blur, m_nf, m_nd};
  endfunction

  initial forever begin
    @(negedge nCLK);
    model_step();
  end

  // per-cycle compare against the model
  initial forever begin
    @(posedge nCLK);
    if (chk_en) begin
      check("deblurparams", 16'(deblurparams_o), 16'(exp_dbp()));
      check("vinfo_valid", 16'(vinfo_valid_o), 16'(m_frames >= 2));
      check("line_cnt", 16'(dut.line_cnt_q), 16'(m_lines));
      check("last_lines", 16'(dut.last_lines_q), 16'(m_last));
    end
  end

  // driver helpers
  function automatic logic [6:0] sw(input logic nv, input logic nh);
    return {3'b000, nv, 1'b0, nh, 1'b1};
  endfunction

  task automatic word(input logic nd, input logic [6:0] d);
    @(posedge nCLK);
    nDSYNC = nd;
    D_i    = d;
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      word(1'b0, sw(1'b1, 1'b0));
      word(1'b0, sw(1'b1, 1'b1));
    end
  endtask

  task automatic frame_edge();
    word(1'b0, sw(1'b0, 1'b1));
  endtask

  task automatic do_reset();
    @(posedge nCLK);
    RST    = 1'b1;
    nDSYNC = 1'b1;
    @(posedge nCLK);
    @(posedge nCLK);
    RST = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge nCLK);
    chk_en = 1;
    check("rst_dbp", 16'(deblurparams_o), 16'h0003);
    check("rst_valid", 16'(vinfo_valid_o), 16'h0000);
    check("rst_sync", 16'(dut.sync_q), 16'h0007);
    RST = 1'b0;

    // S1: 10 pixels, data_cnt tags and blurry position
    for (int i = 0; i < 10; i++) begin
      word(1'b0, sw(1'b1, (i == 0) ? 1'b0 : 1'b1));
      #6;
      check("s1_dcnt_sync", 16'(deblurparams_o[6:5]), 16'h1);
      check("s1_blur", 16'(deblurparams_o[2]), 16'(i % 2));
      for (int k = 1; k < 4; k++) begin
        word(1'b1, 7'($urandom));
        #6;
        check("s1_dcnt_rgb", 16'(deblurparams_o[6:5]), 16'((k + 1) % 4));
      end
    end

    // S2: 263-line frames -> NTSC, progressive, valid after 2nd boundary
    do_reset();
    frame_edge(); #6;
    check("s2_valid_f1", 16'(vinfo_valid_o), 16'h0);
    lines(263);
    frame_edge(); #6;
    check("s2_valid_f2", 16'(vinfo_valid_o), 16'h1);
    lines(263);
    frame_edge();
    lines(263);
    frame_edge(); #6;
    check("s2_vmode", 16'(deblurparams_o[3]), 16'h0);
    check("s2_480i", 16'(deblurparams_o[4]), 16'h0);
    check("s2_last", 16'(dut.last_lines_q), 16'd263);

    // S3: alternating 312/313 -> PAL, 480i after two disagreeing frames
    do_reset();
    nForceDeBlur_i = 1'b0;
    nDeBlurMan_i   = 1'b0;
    frame_edge();
    lines(312);
    frame_edge();
    lines(313);
    frame_edge(); #6;
    check("s3_vmode", 16'(deblurparams_o[3]), 16'h1);
    check("s3_480i_first", 16'(deblurparams_o[4]), 16'h0);
    lines(312);
    frame_edge(); #6;
    check("s3_480i_second", 16'(deblurparams_o[4]), 16'h1);

    // S6: reset mid-line with 150 lines counted
    lines(150);
    word(1'b1, 7'($urandom)); #6;
    check("s6_pre_lines", 16'(dut.line_cnt_q), 16'd150);
    @(posedge nCLK);
    RST = 1'b1;
    #6;
    check("s6_dbp", 16'(deblurparams_o), 16'h0003);
    check("s6_valid", 16'(vinfo_valid_o), 16'h0);
    check("s6_lines", 16'(dut.line_cnt_q), 16'h0);
    check("s6_last", 16'(dut.last_lines_q), 16'h0);
    check("s6_hyst", 16'(dut.hyst_q), 16'h0);
    check("s6_sync", 16'(dut.sync_q), 16'h7);
    @(posedge nCLK);
    RST = 1'b0;
    lines(4); #6;
    check("s6_resume", 16'(dut.line_cnt_q), 16'd4);

    // S4: simultaneous hsync/vsync fall, then line-count saturation
    word(1'b0, sw(1'b0, 1'b0)); #6;
    check("s4_lines", 16'(dut.line_cnt_q), 16'h0);
    check("s4_last", 16'(dut.last_lines_q), 16'd4);
    word(1'b0, sw(1'b1, 1'b1));
    lines(1030); #6;
    check("sat_lines", 16'(dut.line_cnt_q), 16'd1023);
    frame_edge(); #6;
    check("sat_last", 16'(dut.last_lines_q), 16'd1023);
    check("sat_vmode", 16'(deblurparams_o[3]), 16'h1);

    // S5: user settings change mid-frame, take effect at next frame
    lines(3);
    nForceDeBlur_i = 1'b1;
    nDeBlurMan_i   = 1'b1;
    lines(3); #6;
    check("s5_hold_force", 16'(deblurparams_o[1]), 16'h0);
    check("s5_hold_man", 16'(deblurparams_o[0]), 16'h0);
    frame_edge(); #6;
    check("s5_new_force", 16'(deblurparams_o[1]), 16'h1);
    check("s5_new_man", 16'(deblurparams_o[0]), 16'h1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      @(posedge nCLK);
      nDSYNC = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      D_i    = 7'($urandom);
      if ($urandom_range(0, 31) == 0) nForceDeBlur_i = ~nForceDeBlur_i;
      if ($urandom_range(0, 31) == 0) nDeBlurMan_i = ~nDeBlurMan_i;
      RST = ($urandom_range(0, 299) == 0);
    end
    @(posedge nCLK);
    RST = 1'b0;
    repeat (3) @(posedge nCLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
